// File: rtl/srl8_arbiter.sv
// srl8_arbiter: two-requester round-robin front end for one shared 8-bit
// logical-right-shift datapath. Operands are captured on accept, the shift
// result is captured one cycle later, and the result is then held until the
// owning requester takes it.

// Combinational SRL8: C = A >> B with zero fill. Every bit of B is significant.
module srl8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] c
);
  // Any amount of 8 or more, including stray upper bits, shifts every bit out.
  assign c = (b[7:3] != 5'd0) ? 8'h00 : (a >> b[2:0]);
endmodule

module srl8_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       prio;    // requester that wins a tie
  logic       owner;   // requester whose operation is in flight
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] shift_c;
  logic       grant1;
  logic       idle;
  logic       accept;

  // Round-robin grant: a lone requester wins outright, a tie goes to prio.
  assign grant1 = req1_valid & (~req0_valid | prio);
  assign idle   = (state == IDLE);

  // No grant is issued while reset is held, even if a requester is valid.
  assign req0_ready = rst_n & idle & req0_valid & ~grant1;
  assign req1_ready = rst_n & idle & grant1;
  assign accept     = req0_ready | req1_ready;

  assign busy = ~idle;

  // The shifter only ever sees the registered operands.
  srl8 u_srl8 (
    .a (op_a),
    .b (op_b),
    .c (shift_c)
  );

  // Control FSM with registered operands, result and response valids.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are reset along with control so a
      // dropped in-flight operation leaves no stale data visible on rsp_data.
      state      <= IDLE;
      prio       <= RR_INIT;
      owner      <= 1'b0;
      op_a       <= 8'h00;
      op_b       <= 8'h00;
      rsp_data   <= 8'h00;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant1;
            op_a  <= grant1 ? req1_a : req0_a;
            op_b  <= grant1 ? req1_b : req0_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= shift_c;
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          // Hold the result until the owner takes it; prio flips only here.
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            prio       <= ~owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srl8_arbiter.sv
// Self-checking bench for srl8_arbiter: directed sequences, a table of
// shift-amount vectors, and randomized traffic against a behavioural model.
module tb_srl8_arbiter;

  localparam bit RR_INIT = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rsp_data;
  logic       busy;

  srl8_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift: division by a power of two, zero once the amount reaches 8.
  function automatic logic [7:0] ref_srl(input logic [7:0] a, input logic [7:0] b);
    int q;
    if (int'(b) >= 8) return 8'h00;
    q = int'(a) / (2 ** int'(b));
    return q[7:0];
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Wait (bounded) for a ready; returns 0 or 1, or -1 on timeout.
  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready) begin who = 0; break; end
      if (req1_ready) begin who = 1; break; end
      step();
    end
    if (who < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  // One complete operation for requester n with its response consumed at once.
  task automatic serve(input int n, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] data);
    int who;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    if (n == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    wait_grant(who);
    check("serve_grant", who, n);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check("serve_rsp_valid", (n == 0) ? rsp0_valid : rsp1_valid, 1);
    data = rsp_data;
    step();
  endtask

  int         who, exp_w, delay, prio_model;
  logic [7:0] got, exp_d;
  logic [3:0] v;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #3;
    // Reset state, with a valid request pending.
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    do_reset();

    // Single request: 0xB5 >> 3.
    req0_valid = 1'b1; req0_a = 8'hB5; req0_b = 8'd3; rsp0_ready = 1'b1;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    check("single_busy_idle", busy, 0);
    step();
    req0_valid = 1'b0;
    check("single_busy_exec", busy, 1);
    check("single_rsp_early", rsp0_valid, 0);
    step();
    check("single_rsp0_valid", rsp0_valid, 1);
    check("single_rsp_data", rsp_data, 8'h16);
    check("single_rsp1_valid", rsp1_valid, 0);
    check("single_busy_resp", busy, 1);
    step();
    check("single_busy_done", busy, 0);
    check("single_rsp0_clear", rsp0_valid, 0);
    clear_inputs();

    // Contention from reset: grants alternate starting with RR_INIT.
    do_reset();
    req0_valid = 1'b1; req0_a = 8'hB5; req0_b = 8'd1;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    exp_w = int'(RR_INIT);
    for (int k = 0; k < 6; k++) begin
      wait_grant(who);
      check("cont_grant", who, exp_w);
      check("cont_single_ready", req0_ready & req1_ready, 0);
      step();
      step();
      check("cont_rsp_valid", (exp_w == 0) ? rsp0_valid : rsp1_valid, 1);
      check("cont_other_valid", (exp_w == 0) ? rsp1_valid : rsp0_valid, 0);
      check("cont_rsp_data", rsp_data, (exp_w == 0) ? 8'h5A : 8'h0F);
      step();
      exp_w = 1 - exp_w;
    end
    clear_inputs();

    // Shift-amount table, alternating requesters.
    vecs[0]  = '{8'hB5, 8'd0,  8'hB5};
    vecs[1]  = '{8'hB5, 8'd1,  8'h5A};
    vecs[2]  = '{8'hB5, 8'd2,  8'h2D};
    vecs[3]  = '{8'hB5, 8'd3,  8'h16};
    vecs[4]  = '{8'hB5, 8'd4,  8'h0B};
    vecs[5]  = '{8'hB5, 8'd5,  8'h05};
    vecs[6]  = '{8'hB5, 8'd6,  8'h02};
    vecs[7]  = '{8'hB5, 8'd7,  8'h01};
    vecs[8]  = '{8'hB5, 8'd8,  8'h00};
    vecs[9]  = '{8'hB5, 8'h62, 8'h00};
    vecs[10] = '{8'hFF, 8'd4,  8'h0F};
    vecs[11] = '{8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 12; i++) begin
      serve(i % 2, vecs[i].a, vecs[i].b, got);
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end
    clear_inputs();

    // Backpressure on requester 1 while requester 0 waits.
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'd2;
    wait_grant(who);
    check("bp_grant1", who, 1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'd2;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_hold", rsp1_valid, 1);
      check("bp_data_hold", rsp_data, 8'h20);
      check("bp_req0_blocked", req0_ready, 0);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
    check("bp_rsp1_clear", rsp1_valid, 0);
    check("bp_idle", busy, 0);
    check("bp_req0_granted", req0_ready, 1);
    rsp0_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    check("bp_rsp0_data", rsp_data, 8'h0F);
    check("bp_rsp0_valid", rsp0_valid, 1);
    step();
    clear_inputs();

    // Reset during EXEC (prio is 1 here since requester 0 finished last).
    req0_valid = 1'b1; req0_a = 8'hB5; req0_b = 8'd0;
    wait_grant(who);
    step();
    req0_valid = 1'b0;
    check("rx_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rx_busy", busy, 0);
    check("rx_rsp0_valid", rsp0_valid, 0);
    check("rx_rsp_data", rsp_data, 8'h00);
    step();
    rst_n = 1'b1;
    // Complete one req0 op so prio is 1 before the next reset.
    serve(0, 8'hF0, 8'd1, got);
    check("rx_mid_data", got, 8'h78);
    // Reset during RESP of a requester 1 op.
    clear_inputs();
    req1_valid = 1'b1; req1_a = 8'hC3; req1_b = 8'd1;
    wait_grant(who);
    step();
    req1_valid = 1'b0;
    step();
    check("rr_rsp1_before", rsp1_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rr_rsp1_valid", rsp1_valid, 0);
    check("rr_rsp0_valid", rsp0_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_rsp_data", rsp_data, 8'h00);
    step();
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_no_stale", {rsp1_valid, rsp0_valid, busy}, 3'b000);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rr_prio_init0", req0_ready, (RR_INIT == 1'b0) ? 1 : 0);
    check("rr_prio_init1", req1_ready, (RR_INIT == 1'b1) ? 1 : 0);
    clear_inputs();
    do_reset();

    // Operand isolation: scramble inputs after accept.
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'd4; rsp1_ready = 1'b0;
    wait_grant(who);
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      step();
      check("iso_data", rsp_data, 8'h0F);
    end
    rsp1_ready = 1'b1;
    step();
    clear_inputs();

    // Randomized traffic against the model.
    do_reset();
    prio_model = int'(RR_INIT);
    for (int it = 0; it < 150; it++) begin
      v = 4'($urandom_range(1, 3));
      req0_valid = v[0]; req1_valid = v[1];
      req0_a = 8'($urandom); req1_a = 8'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      req1_b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      if (v[0] && v[1]) exp_w = prio_model;
      else              exp_w = v[1] ? 1 : 0;
      exp_d = (exp_w == 1) ? ref_srl(req1_a, req1_b) : ref_srl(req0_a, req0_b);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      wait_grant(who);
      check("rnd_grant", who, exp_w);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      delay = int'($urandom_range(0, 3));
      for (int d = 0; d < delay; d++) begin
        check("rnd_hold", (exp_w == 1) ? rsp1_valid : rsp0_valid, 1);
        step();
      end
      check("rnd_data", rsp_data, exp_d);
      check("rnd_other", (exp_w == 1) ? rsp0_valid : rsp1_valid, 0);
      if (exp_w == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      step();
      check("rnd_done", {rsp1_valid, rsp0_valid, busy}, 3'b000);
      prio_model = 1 - exp_w;
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
